pipeline_mem_stage: RTL
=======================

# pipeline_mem_stage

Memory-access stage of the five-stage pipeline. Sits between the EX/MEM register and the register-file write port. It drives the data-memory port with byte enables and store-lane replication, and holds the pipeline with a stall while memory is not ready. It aligns and extends load data, and registers the MEM/WB stage for write-back.

## Interface
- `TIMEOUT`, 15: maximum cycles `dmemReq` stays asserted without `dmemReady` before the access is aborted.
- `clk` in 1: pipeline clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `exMemValid` in 1: EX/MEM slot holds a real instruction.
- `aluResult` in 32: effective address for memory ops, or result for ALU ops.
- `storeData` in 32: rS2 value for stores.
- `exMemRw` in 5: destination register.
- `memCtrl` in 5: bit0 memRead, bit1 memWrite, bits3:2 dataSize (00 byte, 01 half, 10 word), bit4 loadSigned.
- `wrCtrl` in 2: bit0 regWrite, bit1 memToReg.
- `dmemReq`, `dmemWe` out 1: memory request and write strobe.
- `dmemAddr` out 32: `{aluResult[31:2],2'b00}`.
- `dmemByteEn` out 4: lane enables, bit3 = bits 31:24.
- `dmemWdata` out 32; `dmemRdata` in 32; `dmemReady` in 1.
- `memStall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- `memWbValid`, `memWbRegWrite` out 1; `memWbRw` out 5; `memWbData` out 32: MEM/WB register.
- `misalignErr`, `busErr` out 1: sticky error flags, cleared only by reset.

## Operation
- Endianness is big-endian: address offset 0 maps to bits 31:24.
- Byte enables:
  - Byte access: one-hot `4'b1000 >> addr[1:0]`.
  - Half access: `4'b1100` at offset 0, `4'b0011` at offset 2.
  - Word access: `4'b1111`.
- Store data is replicated: byte into all four lanes, half into both halves.
- Loads select the lane, then zero- or sign-extend according to `loadSigned`. Word loads pass through unchanged.
- Misaligned accesses are a half with `addr[0]=1` or a word with `addr[1:0]!=0`. For these:
  - No `dmemReq` is issued.
  - `misalignErr` is set.
  - The slot retires with `memWbRegWrite=0`.
- Non-memory valid ops pass through in one cycle with `memWbData = aluResult`. `memToReg=0` selects the ALU result and no memory access occurs.
- FSM state `IDLE`:
  - A valid aligned memory op asserts `dmemReq` combinationally.
  - If `dmemReady` is high the same cycle, the op completes and the FSM stays in `IDLE`.
  - Otherwise the FSM moves to `WAIT` and `memStall=1`.
- FSM state `WAIT`:
  - `dmemReq` stays high with address, enables and data held stable.
  - The wait counter increments each cycle.
  - `dmemReady` completes the op and returns the FSM to `IDLE`.
  - When the counter reaches `TIMEOUT`, `dmemReq` deasserts and `busErr` is set. The slot retires with `memWbRegWrite=0` and the FSM returns to `IDLE`.
- `memStall` = `dmemReq && !dmemReady && !timeoutHit`.
- The MEM/WB register loads only when `memStall=0`. While stalled it loads a bubble (`memWbValid=0`, `memWbRegWrite=0`) so write-back never repeats a retired op.
- An invalid slot (`exMemValid=0`) issues no request and produces a bubble.

## Timing
- Reset values: all outputs 0, FSM in `IDLE`, counter 0, both sticky flags 0.
- Reset asserted during `WAIT`:
  - `dmemReq` is 0 from the next edge onward.
  - The in-flight store is abandoned with no retry.
- Latency:
  - Zero-wait access: MEM/WB visible one edge after the op enters EX/MEM.
  - N-wait access: visible N+1 edges after entry.
- A store completes on the `dmemReady` cycle. `dmemWe` is never asserted without `dmemReq`.
- `dmemReady` asserted while `dmemReq=0` is ignored.
- `dmemReady` and timeout arriving in the same cycle: `dmemReady` wins and no `busErr` is set.
- The counter width is `$clog2(TIMEOUT+1)` and the counter clears on every transition to `IDLE`.

## Structure
- Shared `pipeline_pkg` holds:
  - dataSize encodings.
  - `memCtrl`/`wrCtrl` bit-position constants.
  - The `IDLE`/`WAIT` state enum.
- Sub-module `pipeline_load_align` is purely combinational. Inputs are `addr[1:0]`, dataSize, `loadSigned` and `rdata`; the output is the aligned 32-bit value. The bench reuses it as its reference model.
- The byte-enable and store-replication logic stays inline.

## Test plan
- ALU op passthrough: `aluResult=0x12345678`, regWrite=1, `rW=7` → next edge `memWbData=0x12345678`, `memWbRw=7`; `dmemReq` never asserted.
- Signed byte load: addr `0x1003`, `rdata=0xAABBCC80`, `dmemReady` tied high → `dmemByteEn=0001`, `memWbData=0xFFFFFF80`.
- Unsigned load: same as previous with `loadSigned=0` → `memWbData=0x00000080`.
- Half store: addr `0x2002`, `storeData=0x0000BEEF`, `dmemReady` delayed 3 cycles → `dmemWdata=0xBEEFBEEF`, `dmemByteEn=0011`, `memStall` high exactly 3 cycles, one MEM/WB bubble per stall cycle.
- Misaligned word load: addr `0x3001` → no `dmemReq`, `misalignErr=1` and it stays 1, `memWbRegWrite=0`.
- Timeout: `dmemReady` held low, `TIMEOUT=15` → `memStall` high for 15 cycles then drops, `busErr=1`, writeback suppressed.
- Reset mid-access: reset during `WAIT` → `dmemReq=0` and all flags 0 after the edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline: memCtrl/wrCtrl bit positions,
// access-size codes and the memory-stage FSM states.
`timescale 1ns/1ps
package pipeline_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam int MC_READ    = 0;
   localparam int MC_WRITE   = 1;
   localparam int MC_SIZE_LO = 2;
   localparam int MC_SIGNED  = 4;

   localparam int WC_REG_WRITE  = 0;
   localparam int WC_MEM_TO_REG = 1;

   typedef enum logic {
      IDLE,
      WAIT
   } mem_state_e;

endpackage

// File: rtl/pipeline_load_align.sv
// Big-endian load lane selection with zero/sign extension.
`timescale 1ns/1ps
module pipeline_load_align
   import pipeline_pkg::*;
(
   input  logic [1:0]  i_addr,
   input  logic [1:0]  i_data_size,
   input  logic        i_load_signed,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Offset 0 is the most significant lane.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_byte = i_rdata[31:24];
      case (i_addr)
         2'd0:    w_byte = i_rdata[31:24];
         2'd1:    w_byte = i_rdata[23:16];
         2'd2:    w_byte = i_rdata[15:8];
         default: w_byte = i_rdata[7:0];
      endcase
   end

   assign w_half = i_addr[1] ? i_rdata[15:0] : i_rdata[31:16];

   always_comb begin
      o_data = i_rdata;
      case (i_data_size)
         SIZE_BYTE: o_data = {{24{i_load_signed & w_byte[7]}}, w_byte};
         SIZE_HALF: o_data = {{16{i_load_signed & w_half[15]}}, w_half};
         default:   o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/pipeline_mem_stage.sv
// Memory-access stage: drives the data-memory port, stalls on a slow memory
// with a bounded wait, aligns load data and registers MEM/WB.
`timescale 1ns/1ps
module pipeline_mem_stage
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT = 15
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        exMemValid,
   input  logic [31:0] aluResult,
   input  logic [31:0] storeData,
   input  logic [4:0]  exMemRw,
   input  logic [4:0]  memCtrl,
   input  logic [1:0]  wrCtrl,
   output logic        dmemReq,
   output logic        dmemWe,
   output logic [31:0] dmemAddr,
   output logic [3:0]  dmemByteEn,
   output logic [31:0] dmemWdata,
   input  logic [31:0] dmemRdata,
   input  logic        dmemReady,
   output logic        memStall,
   output logic        memWbValid,
   output logic        memWbRegWrite,
   output logic [4:0]  memWbRw,
   output logic [31:0] memWbData,
   output logic        misalignErr,
   output logic        busErr
);

   localparam int CW = $clog2(TIMEOUT + 1);

   mem_state_e    r_state;
   mem_state_e    w_state_nxt;
   logic [CW-1:0] r_wait_cnt;

   logic        r_wb_valid, r_wb_reg_write, r_misalign_err, r_bus_err;
   logic [4:0]  r_wb_rw;
   logic [31:0] r_wb_data;

   logic [1:0]  w_size, w_off;
   logic        w_mem_read, w_mem_write, w_mem_op;
   logic        w_bad_align, w_misalign;
   logic        w_req, w_timeout_hit, w_abort, w_stall;
   logic [3:0]  w_byte_en;
   logic [31:0] w_wdata, w_load_data;

   assign w_size      = memCtrl[MC_SIZE_LO +: 2];
   assign w_off       = aluResult[1:0];
   assign w_mem_read  = exMemValid && memCtrl[MC_READ];
   assign w_mem_write = exMemValid && memCtrl[MC_WRITE];
   assign w_mem_op    = w_mem_read || w_mem_write;

   always_comb begin
      w_bad_align = 1'b0;
      case (w_size)
         SIZE_BYTE: w_bad_align = 1'b0;
         SIZE_HALF: w_bad_align = w_off[0];
         default:   w_bad_align = (w_off != 2'b00);
      endcase
   end

   assign w_misalign = w_mem_op && w_bad_align;

   // Request generation and next state; reset masks the request immediately.
   always_comb begin
      w_state_nxt   = r_state;
      w_req         = 1'b0;
      w_timeout_hit = 1'b0;
      if (!reset) begin
         case (r_state)
            IDLE: begin
               w_req = w_mem_op && !w_misalign;
               if (w_req && !dmemReady) w_state_nxt = WAIT;
            end
            WAIT: begin
               w_req         = 1'b1;
               w_timeout_hit = (r_wait_cnt == CW'(TIMEOUT));
               if (dmemReady || w_timeout_hit) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign w_stall = w_req && !dmemReady && !w_timeout_hit;
   assign w_abort = w_timeout_hit && !dmemReady;

   always_comb begin
      w_byte_en = 4'b1111;
      w_wdata   = storeData;
      case (w_size)
         SIZE_BYTE: begin
            w_byte_en = 4'b1000 >> w_off;
            w_wdata   = {4{storeData[7:0]}};
         end
         SIZE_HALF: begin
            w_byte_en = w_off[1] ? 4'b0011 : 4'b1100;
            w_wdata   = {2{storeData[15:0]}};
         end
         default: begin
            w_byte_en = 4'b1111;
            w_wdata   = storeData;
         end
      endcase
   end

   pipeline_load_align u_load_align (
      .i_addr        (w_off),
      .i_data_size   (w_size),
      .i_load_signed (memCtrl[MC_SIGNED]),
      .i_rdata       (dmemRdata),
      .o_data        (w_load_data)
   );

   // EX/MEM is frozen during a stall, so the port stays stable in WAIT.
   assign dmemReq    = w_req;
   assign dmemWe     = w_req && w_mem_write;
   assign dmemAddr   = w_req ? {aluResult[31:2], 2'b00} : 32'h0;
   assign dmemByteEn = w_req ? w_byte_en : 4'b0000;
   assign dmemWdata  = w_req ? w_wdata : 32'h0;
   assign memStall   = w_stall;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         r_state    <= IDLE;
         r_wait_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_state_nxt == IDLE) r_wait_cnt <= '0;
         else                     r_wait_cnt <= r_wait_cnt + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wb_valid     <= 1'b0;
         r_wb_reg_write <= 1'b0;
         r_wb_rw        <= '0;
         r_wb_data      <= '0;
         r_misalign_err <= 1'b0;
         r_bus_err      <= 1'b0;
      end else begin
         if (w_stall) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_rw        <= '0;
            r_wb_data      <= '0;
         end else begin
            r_wb_valid     <= exMemValid;
            r_wb_reg_write <= exMemValid && wrCtrl[WC_REG_WRITE] && !w_misalign && !w_abort;
            r_wb_rw        <= exMemValid ? exMemRw : 5'd0;
            if (!exMemValid)                            r_wb_data <= '0;
            else if (wrCtrl[WC_MEM_TO_REG] && w_mem_read) r_wb_data <= w_load_data;
            else                                        r_wb_data <= aluResult;
         end
         if (w_misalign) r_misalign_err <= 1'b1;
         if (w_abort)    r_bus_err      <= 1'b1;
      end
   end

   assign memWbValid    = r_wb_valid;
   assign memWbRegWrite = r_wb_reg_write;
   assign memWbRw       = r_wb_rw;
   assign memWbData     = r_wb_data;
   assign misalignErr   = r_misalign_err;
   assign busErr        = r_bus_err;

endmodule
